// File: rtl/mc_ctrl_pkg.sv
// Shared state, opcode and control-word definitions for the multicycle main decoder.
// No logic of its own; imported by mc_state_outdec and mc_maindec.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11,
    S_JREX    = 4'd12
  } mc_state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;
  localparam logic [1:0] ALU_SLT   = 2'd3;

  typedef struct packed {
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       branch_ne;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_J: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_state_outdec.sv
// Combinational state -> control-word table; zero latency, mem_done gates FETCH loads.
// Unused state encodings produce an all-zero control word.
module mc_state_outdec
  import mc_ctrl_pkg::*;
(
  input  mc_state_t   state,
  input  logic [5:0]  op,
  input  logic        mem_done,
  output ctrl_t       ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.alusrcb = 2'b01;
        ctrl.aluop   = ALU_ADD;
        ctrl.irwrite = mem_done;
        ctrl.pcwrite = mem_done;
      end
      S_DECODE: begin
        ctrl.alusrcb    = 2'b11;
        ctrl.aluop      = ALU_ADD;
        ctrl.illegal_op = ~is_legal_op(op);
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        ctrl.aluop   = ALU_ADD;
      end
      S_MEMRD: ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      // Write strobe stays up for the whole wait, not just the completing cycle.
      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b00;
        ctrl.aluop   = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca   = 1'b1;
        ctrl.alusrcb   = 2'b00;
        ctrl.aluop     = ALU_SUB;
        ctrl.pcsrc     = 2'b01;
        ctrl.branch    = (op == OP_BEQ);
        ctrl.branch_ne = (op == OP_BNE);
      end
      S_IMMEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        ctrl.aluop   = (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      S_IMMWB: ctrl.regwrite = 1'b1;
      S_JUMP: begin
        ctrl.pcsrc   = 2'b10;
        ctrl.pcwrite = 1'b1;
      end
      S_JREX: begin
        ctrl.pcsrc   = 2'b11;
        ctrl.pcwrite = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_maindec.sv
// Multicycle MIPS main decoder FSM; one state per cycle, 2..5 cycles per instruction.
// Memory stalls hold FETCH/MEMRD/MEMWR until mem_ready (ignored when MEM_WAIT_EN=0).
module mc_maindec
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W     = 2,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  output logic               iord,
  output logic               irwrite,
  output logic               pcwrite,
  output logic               branch,
  output logic               branch_ne,
  output logic               memwrite,
  output logic               regwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [ALUOP_W-1:0] aluop,
  output logic               illegal_op
);

  mc_state_t state, state_nxt;
  logic      mem_done;
  ctrl_t     ctrl, ctrl_g;

  assign mem_done = MEM_WAIT_EN ? mem_ready : 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:  state_nxt = mem_done ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:   state_nxt = S_MEMADR;
          OP_RTYPE:       state_nxt = (funct == FN_JR) ? S_JREX : S_EXECUTE;
          OP_BEQ, OP_BNE: state_nxt = S_BRANCH;
          OP_ADDI, OP_SLTI: state_nxt = S_IMMEX;
          OP_J:           state_nxt = S_JUMP;
          default:        state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR:  state_nxt = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_nxt = mem_done ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_nxt = mem_done ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_nxt = S_ALUWB;
      S_IMMEX:   state_nxt = S_IMMWB;
      default:   state_nxt = S_FETCH;
    endcase
  end

  mc_state_outdec u_outdec (
    .state    (state),
    .op       (op),
    .mem_done (mem_done),
    .ctrl     (ctrl)
  );

  // Outputs forced quiet for the whole reset pulse, not just after the state update.
  assign ctrl_g = reset ? '0 : ctrl;

  always_comb begin
    aluop      = '0;
    aluop[1:0] = ctrl_g.aluop;
  end

  assign iord       = ctrl_g.iord;
  assign irwrite    = ctrl_g.irwrite;
  assign pcwrite    = ctrl_g.pcwrite;
  assign branch     = ctrl_g.branch;
  assign branch_ne  = ctrl_g.branch_ne;
  assign memwrite   = ctrl_g.memwrite;
  assign regwrite   = ctrl_g.regwrite;
  assign regdst     = ctrl_g.regdst;
  assign memtoreg   = ctrl_g.memtoreg;
  assign alusrca    = ctrl_g.alusrca;
  assign alusrcb    = ctrl_g.alusrcb;
  assign pcsrc      = ctrl_g.pcsrc;
  assign illegal_op = ctrl_g.illegal_op;

endmodule

// File: tb/tb_mc_maindec.sv
// Directed bench for mc_maindec: stimulus pushes the hand-derived control word per cycle,
// a negedge monitor pops and compares it against the DUT outputs.
module tb_mc_maindec;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       mem_ready;
  logic       iord, irwrite, pcwrite, branch, branch_ne, memwrite, regwrite;
  logic       regdst, memtoreg, alusrca, illegal_op;
  logic [1:0] alusrcb, pcsrc, aluop;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mc_maindec #(.ALUOP_W(2), .MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_ready(mem_ready),
    .iord(iord), .irwrite(irwrite), .pcwrite(pcwrite), .branch(branch),
    .branch_ne(branch_ne), .memwrite(memwrite), .regwrite(regwrite),
    .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .aluop(aluop), .illegal_op(illegal_op)
  );

  // {iord irwrite pcwrite branch branch_ne memwrite regwrite regdst memtoreg alusrca alusrcb pcsrc aluop illegal_op}
  function automatic logic [16:0] pk(input logic io, irw, pcw, br, bne, mw, rw, rd, m2r, asa,
                                     input logic [1:0] asb, pcs, aop, input logic ill);
    return {io, irw, pcw, br, bne, mw, rw, rd, m2r, asa, asb, pcs, aop, ill};
  endfunction

  localparam logic [16:0] E_ZERO  = 17'd0;
  localparam logic [16:0] E_FR    = pk(0,1,1,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0);
  localparam logic [16:0] E_FW    = pk(0,0,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0);
  localparam logic [16:0] E_DEC   = pk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0);
  localparam logic [16:0] E_DECI  = pk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,1);
  localparam logic [16:0] E_MA    = pk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
  localparam logic [16:0] E_MR    = pk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
  localparam logic [16:0] E_MWB   = pk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0);
  localparam logic [16:0] E_MW    = pk(1,0,0,0,0,1,0,0,0,0,2'b00,2'b00,2'b00,0);
  localparam logic [16:0] E_EX    = pk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,2'b10,0);
  localparam logic [16:0] E_AWB   = pk(0,0,0,0,0,0,1,1,0,0,2'b00,2'b00,2'b00,0);
  localparam logic [16:0] E_BEQ   = pk(0,0,0,1,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
  localparam logic [16:0] E_BNE   = pk(0,0,0,0,1,0,0,0,0,1,2'b00,2'b01,2'b01,0);
  localparam logic [16:0] E_IADD  = pk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
  localparam logic [16:0] E_ISLT  = pk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b11,0);
  localparam logic [16:0] E_IWB   = pk(0,0,0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00,0);
  localparam logic [16:0] E_J     = pk(0,0,1,0,0,0,0,0,0,0,2'b00,2'b10,2'b00,0);
  localparam logic [16:0] E_JR    = pk(0,0,1,0,0,0,0,0,0,0,2'b00,2'b11,2'b00,0);

  typedef struct {
    logic [16:0] v;
    string       nm;
  } exp_t;

  exp_t sb[$];

  task automatic step(input logic rs, input logic [5:0] o, input logic [5:0] f,
                      input logic mr, input logic [16:0] e, input string nm);
    exp_t x;
    reset     = rs;
    op        = o;
    funct     = f;
    mem_ready = mr;
    x.v  = e;
    x.nm = nm;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      logic [16:0] act;
      x   = sb.pop_front();
      act = {iord, irwrite, pcwrite, branch, branch_ne, memwrite, regwrite, regdst,
             memtoreg, alusrca, alusrcb, pcsrc, aluop, illegal_op};
      total++;
      if (act !== x.v) begin
        bad++;
        $display("FAIL %s: got %b expected %b", x.nm, act, x.v);
      end
    end
  end

  initial begin
    reset = 1'b1; op = 6'd0; funct = 6'd0; mem_ready = 1'b1;
    @(posedge clk); #1;
    step(1, 6'b000000, 6'd0, 1, E_ZERO, "reset_outputs0");
    step(1, 6'b100011, 6'd0, 1, E_ZERO, "reset_outputs1");
    // LW, no wait
    step(0, 6'b100011, 6'd0, 1, E_FR,  "lw_fetch");
    step(0, 6'b100011, 6'd0, 1, E_DEC, "lw_decode");
    step(0, 6'b100011, 6'd0, 1, E_MA,  "lw_memadr");
    step(0, 6'b100011, 6'd0, 1, E_MR,  "lw_memrd");
    step(0, 6'b100011, 6'd0, 1, E_MWB, "lw_memwb");
    // SW with three stall cycles in MEMWR
    step(0, 6'b101011, 6'd0, 1, E_FR,  "sw_fetch");
    step(0, 6'b101011, 6'd0, 1, E_DEC, "sw_decode");
    step(0, 6'b101011, 6'd0, 1, E_MA,  "sw_memadr");
    step(0, 6'b101011, 6'd0, 0, E_MW,  "sw_memwr_w1");
    step(0, 6'b101011, 6'd0, 0, E_MW,  "sw_memwr_w2");
    step(0, 6'b101011, 6'd0, 0, E_MW,  "sw_memwr_w3");
    step(0, 6'b101011, 6'd0, 1, E_MW,  "sw_memwr_done");
    // R-type with a two-cycle fetch stall
    step(0, 6'b000000, 6'h20, 0, E_FW,  "r_fetch_w1");
    step(0, 6'b000000, 6'h20, 0, E_FW,  "r_fetch_w2");
    step(0, 6'b000000, 6'h20, 1, E_FR,  "r_fetch");
    step(0, 6'b000000, 6'h20, 1, E_DEC, "r_decode");
    step(0, 6'b000000, 6'h20, 1, E_EX,  "r_execute");
    step(0, 6'b000000, 6'h20, 1, E_AWB, "r_aluwb");
    // BNE and BEQ
    step(0, 6'b000101, 6'd0, 1, E_FR,  "bne_fetch");
    step(0, 6'b000101, 6'd0, 1, E_DEC, "bne_decode");
    step(0, 6'b000101, 6'd0, 1, E_BNE, "bne_branch");
    step(0, 6'b000100, 6'd0, 1, E_FR,  "beq_fetch");
    step(0, 6'b000100, 6'd0, 1, E_DEC, "beq_decode");
    step(0, 6'b000100, 6'd0, 1, E_BEQ, "beq_branch");
    // JR
    step(0, 6'b000000, 6'b001000, 1, E_FR,  "jr_fetch");
    step(0, 6'b000000, 6'b001000, 1, E_DEC, "jr_decode");
    step(0, 6'b000000, 6'b001000, 1, E_JR,  "jr_exec");
    // J
    step(0, 6'b000010, 6'd0, 1, E_FR,  "j_fetch");
    step(0, 6'b000010, 6'd0, 1, E_DEC, "j_decode");
    step(0, 6'b000010, 6'd0, 1, E_J,   "j_jump");
    // illegal opcode returns straight to FETCH
    step(0, 6'b111111, 6'd0, 1, E_FR,   "ill_fetch");
    step(0, 6'b111111, 6'd0, 1, E_DECI, "ill_decode");
    step(0, 6'b111111, 6'd0, 1, E_FR,   "ill_next_fetch");
    // SLTI then ADDI (the ill_next_fetch cycle fetched the SLTI)
    step(0, 6'b001010, 6'd0, 1, E_DEC,  "slti_decode");
    step(0, 6'b001010, 6'd0, 1, E_ISLT, "slti_immex");
    step(0, 6'b001010, 6'd0, 1, E_IWB,  "slti_immwb");
    step(0, 6'b001000, 6'd0, 1, E_FR,   "addi_fetch");
    step(0, 6'b001000, 6'd0, 1, E_DEC,  "addi_decode");
    step(0, 6'b001000, 6'd0, 1, E_IADD, "addi_immex");
    step(0, 6'b001000, 6'd0, 1, E_IWB,  "addi_immwb");
    // reset mid-MEMWR aborts the store
    step(0, 6'b101011, 6'd0, 1, E_FR,   "swr_fetch");
    step(0, 6'b101011, 6'd0, 1, E_DEC,  "swr_decode");
    step(0, 6'b101011, 6'd0, 1, E_MA,   "swr_memadr");
    step(0, 6'b101011, 6'd0, 0, E_MW,   "swr_memwr");
    step(1, 6'b101011, 6'd0, 0, E_ZERO, "swr_reset");
    step(0, 6'b101011, 6'd0, 0, E_FW,   "swr_after_fetch_wait");
    step(0, 6'b101011, 6'd0, 1, E_FR,   "swr_after_fetch");
    step(0, 6'b101011, 6'd0, 1, E_DEC,  "swr_after_decode");
    step(0, 6'b101011, 6'd0, 1, E_MA,   "swr_after_memadr");
    step(0, 6'b101011, 6'd0, 1, E_MW,   "swr_after_memwr");
    step(0, 6'b000010, 6'd0, 1, E_FR,   "final_fetch");
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
